// File: rtl/ls_wb_tracker_if.sv
// Handshake bundle between issue, LSU responses, commit and WAW sources for the
// in-order load/store writeback tracker.
interface ls_wb_tracker_if #(
  parameter int DataW       = 65,
  parameter int NumWawPorts = 2
);
  logic                     alloc_valid_i;
  logic                     alloc_rdy_o;
  logic [4:0]               alloc_rd_i;
  logic                     alloc_we_i;
  logic                     resp_valid_i;
  logic                     resp_rdy_o;
  logic                     resp_err_i;
  logic [DataW-1:0]         resp_data_i;
  logic                     out_valid_o;
  logic                     out_rdy_i;
  logic                     out_we_o;
  logic [4:0]               out_waddr_o;
  logic [DataW-1:0]         out_wdata_o;
  logic                     out_err_o;
  logic                     out_wrsv_o;
  logic [NumWawPorts-1:0]   waw_valid_i;
  logic [5*NumWawPorts-1:0] waw_rd_i;

  modport slave (
    input  alloc_valid_i, alloc_rd_i, alloc_we_i,
    input  resp_valid_i, resp_err_i, resp_data_i,
    input  out_rdy_i, waw_valid_i, waw_rd_i,
    output alloc_rdy_o, resp_rdy_o,
    output out_valid_o, out_we_o, out_waddr_o, out_wdata_o, out_err_o, out_wrsv_o
  );

  modport master (
    output alloc_valid_i, alloc_rd_i, alloc_we_i,
    output resp_valid_i, resp_err_i, resp_data_i,
    output out_rdy_i, waw_valid_i, waw_rd_i,
    input  alloc_rdy_o, resp_rdy_o,
    input  out_valid_o, out_we_o, out_waddr_o, out_wdata_o, out_err_o, out_wrsv_o
  );
endinterface

// File: rtl/ls_wb_tracker.sv
// In-order writeback buffer for load/store ops: allocate at issue, fill from LSU
// responses, drain to commit in order; per-entry write-reserve cleared by younger writers.
module ls_wb_tracker #(
  parameter int Depth       = 4,
  parameter int DataW       = 65,
  parameter int NumWawPorts = 2,
  parameter bit ErrStall    = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   debug_mode_i,
  ls_wb_tracker_if.slave         bus,
  output logic [$clog2(Depth):0] occupancy_o,
  output logic                   err_active_o
);
  localparam int IdxW = $clog2(Depth);
  localparam int PtrW = IdxW + 1;
  typedef logic [PtrW-1:0] ptr_t;

  ptr_t             wp_q, wp_d, fp_q, fp_d, hp_q, hp_d;
  logic             err_lat_q, err_lat_d;
  logic [Depth-1:0] wrsv_q, wrsv_d, filled_q, filled_d;
  logic [Depth-1:0] we_q, we_d, err_q, err_d;
  logic [4:0]       rd_q   [Depth];
  logic [4:0]       rd_d   [Depth];
  logic [DataW-1:0] data_q [Depth];
  logic [DataW-1:0] data_d [Depth];

  logic [IdxW-1:0]  wi, fi, hi;
  ptr_t             count;
  logic             alloc_fire, fill_fire, drain_fire, err_now, out_valid;
  logic [Depth-1:0] waw_hit;

  assign wi    = wp_q[IdxW-1:0];
  assign fi    = fp_q[IdxW-1:0];
  assign hi    = hp_q[IdxW-1:0];
  assign count = wp_q - hp_q;

  // count can reach exactly Depth, so its MSB alone marks full
  assign bus.alloc_rdy_o = ~count[PtrW-1];
  assign bus.resp_rdy_o  = ~err_lat_q;
  assign err_now         = ErrStall & bus.resp_valid_i & bus.resp_err_i & ~debug_mode_i;
  assign err_active_o    = err_lat_q | err_now;
  assign occupancy_o     = count;

  assign alloc_fire = bus.alloc_valid_i & bus.alloc_rdy_o;
  assign fill_fire  = bus.resp_valid_i & bus.resp_rdy_o & (fp_q != wp_q);
  assign out_valid  = filled_q[hi];
  assign drain_fire = out_valid & bus.out_rdy_i;

  // Head fields are masked while empty so stale slot contents never leak out
  assign bus.out_valid_o = out_valid;
  assign bus.out_we_o    = out_valid & we_q[hi];
  assign bus.out_waddr_o = out_valid ? rd_q[hi] : 5'd0;
  assign bus.out_wdata_o = out_valid ? data_q[hi] : '0;
  assign bus.out_err_o   = out_valid & err_q[hi];
  assign bus.out_wrsv_o  = bus.out_we_o & wrsv_q[hi];

  always_comb begin
    waw_hit = '0;
    for (int k = 0; k < NumWawPorts; k++) begin
      for (int e = 0; e < Depth; e++) begin
        if (bus.waw_valid_i[k] && (bus.waw_rd_i[5*k +: 5] != 5'd0) &&
            (bus.waw_rd_i[5*k +: 5] == rd_q[e])) begin
          waw_hit[e] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wp_d      = wp_q;
    fp_d      = fp_q;
    hp_d      = hp_q;
    err_lat_d = err_lat_q;
    wrsv_d    = wrsv_q & ~waw_hit;
    filled_d  = filled_q;
    we_d      = we_q;
    err_d     = err_q;
    rd_d      = rd_q;
    data_d    = data_q;
    if (drain_fire) begin
      wrsv_d[hi]   = 1'b0;
      filled_d[hi] = 1'b0;
      hp_d         = hp_q + ptr_t'(1);
    end
    if (fill_fire) begin
      data_d[fi]   = bus.resp_data_i;
      err_d[fi]    = bus.resp_err_i;
      filled_d[fi] = 1'b1;
      fp_d         = fp_q + ptr_t'(1);
      if (err_now) err_lat_d = 1'b1;
    end
    // Applied after the WAW clear: the entry allocated this cycle is the younger writer
    if (alloc_fire) begin
      rd_d[wi]     = bus.alloc_rd_i;
      we_d[wi]     = bus.alloc_we_i;
      wrsv_d[wi]   = bus.alloc_we_i;
      filled_d[wi] = 1'b0;
      wp_d         = wp_q + ptr_t'(1);
    end
    if (flush_i) begin
      wp_d      = '0;
      fp_d      = '0;
      hp_d      = '0;
      err_lat_d = 1'b0;
      wrsv_d    = '0;
      filled_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q      <= '0;
      fp_q      <= '0;
      hp_q      <= '0;
      err_lat_q <= 1'b0;
      wrsv_q    <= '0;
      filled_q  <= '0;
    end else begin
      wp_q      <= wp_d;
      fp_q      <= fp_d;
      hp_q      <= hp_d;
      err_lat_q <= err_lat_d;
      wrsv_q    <= wrsv_d;
      filled_q  <= filled_d;
    end
  end

  // Payload storage is qualified by filled/wrsv, so it needs no reset
  always_ff @(posedge clk_i) begin
    we_q   <= we_d;
    err_q  <= err_d;
    rd_q   <= rd_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_ls_wb_tracker.sv
// Scoreboard bench for ls_wb_tracker: directed vectors push expected commits,
// a negedge monitor pops and compares each drained head.
module tb_ls_wb_tracker;
  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [64:0] data;
    logic        err;
    logic        wrsv;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       debug;
  logic [2:0] occ;
  logic       err_act;
  int         checks = 0;
  int         errors = 0;
  int         drained = 0;
  int         n_alloc = 0;
  int         n_resp = 0;
  exp_t        exp_q[$];
  logic [64:0] pend_q[$];

  ls_wb_tracker_if #(.DataW(65), .NumWawPorts(2)) bus ();

  ls_wb_tracker #(.Depth(4), .DataW(65), .NumWawPorts(2), .ErrStall(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_mode_i(debug),
    .bus(bus), .occupancy_o(occ), .err_active_o(err_act)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [64:0] d_of(input int i);
    return {1'(i), 32'hDEAD_0000 + 32'(i), 32'h0BAD_0000 + 32'(i * 7)};
  endfunction

  function automatic exp_t mk(input int rd, input logic we, input logic [64:0] d,
                              input logic err, input logic wrsv);
    exp_t e;
    e.rd = 5'(rd); e.we = we; e.data = d; e.err = err; e.wrsv = wrsv;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.waw_valid_i = '0;
    flush = 1'b0;
  endtask

  task automatic drive(input logic av, input int rd, input logic we, input logic rv,
                       input logic re, input logic [64:0] d, input logic ordy);
    bus.alloc_valid_i = av;
    bus.alloc_rd_i    = 5'(rd);
    bus.alloc_we_i    = we;
    bus.resp_valid_i  = rv;
    bus.resp_err_i    = re;
    bus.resp_data_i   = d;
    bus.out_rdy_i     = ordy;
  endtask

  task automatic set_waw(input int port, input int rd);
    bus.waw_valid_i[port]      = 1'b1;
    bus.waw_rd_i[5*port +: 5]  = 5'(rd);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: bench-side alloc/resp bookkeeping and in-order commit comparison
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
      n_alloc = 0;
      n_resp  = 0;
    end else begin
      if (bus.resp_valid_i && bus.resp_rdy_o) begin
        checks++;
        assert (n_resp < n_alloc) else begin
          errors++;
          $display("FAIL resp_without_entry: responses %0d allocs %0d", n_resp, n_alloc);
        end
        if (n_resp < n_alloc) n_resp++;
      end
      if (bus.alloc_valid_i && bus.alloc_rdy_o) n_alloc++;
      if (bus.out_valid_o && bus.out_rdy_i) begin
        exp_t act, e;
        act = {bus.out_waddr_o, bus.out_we_o, bus.out_wdata_o, bus.out_err_o, bus.out_wrsv_o};
        checks++;
        drained++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL commit_unexpected: got rd=%0d data=%0h", act.rd, act.data);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL commit: got rd=%0d we=%0b data=%0h err=%0b wrsv=%0b expected rd=%0d we=%0b data=%0h err=%0b wrsv=%0b",
                     act.rd, act.we, act.data, act.err, act.wrsv, e.rd, e.we, e.data, e.err, e.wrsv);
          end
        end
      end
    end
  end

  initial begin
    int sent, cyc, base;
    logic av, rv, we;
    logic [4:0] rd;
    logic [64:0] rdat, adat;

    rst_n = 1'b0; flush = 1'b0; debug = 1'b0;
    bus.waw_valid_i = '0; bus.waw_rd_i = '0;
    drive(0, 0, 0, 0, 0, '0, 0);
    #3;
    chk("rst_alloc_rdy", 64'(bus.alloc_rdy_o), 64'd1);
    chk("rst_resp_rdy", 64'(bus.resp_rdy_o), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_out_fields", 64'({bus.out_we_o, bus.out_waddr_o, bus.out_err_o, bus.out_wrsv_o}), 64'd0);
    chk("rst_out_wdata", 64'(bus.out_wdata_o), 64'd0);
    chk("rst_occupancy", 64'(occ), 64'd0);
    chk("rst_err_active", 64'(err_act), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: four loads, four responses, in-order commit with one-cycle fill-to-valid latency
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 1, 0, 0, '0, 1);
      exp_q.push_back(mk(i, 1, d_of(i), 0, 1));
      tick();
    end
    drive(0, 0, 0, 0, 0, '0, 1);
    #2;
    chk("t1_occ_full", 64'(occ), 64'd4);
    chk("t1_alloc_rdy_full", 64'(bus.alloc_rdy_o), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 1, 0, d_of(i), 1);
      #2;
      chk("t1_out_valid", 64'(bus.out_valid_o), 64'(i > 1));
      chk("t1_occ", 64'(occ), 64'(i == 1 ? 4 : 6 - i));
      tick();
    end
    drive(0, 0, 0, 0, 0, '0, 1);
    wait_drain("t1_drain");
    chk("t1_occ_empty", 64'(occ), 64'd0);
    chk("t1_drained", 64'(drained), 64'd4);

    // 2: full buffer, drain and alloc request in the same cycle: no drain credit
    for (int i = 0; i < 4; i++) begin
      drive(1, 6 + i, 1, 0, 0, '0, 0);
      exp_q.push_back(mk(6 + i, 1, d_of(6 + i), 0, 1));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, d_of(6 + i), 0);
      tick();
    end
    drive(1, 10, 1, 0, 0, '0, 1);
    #2;
    chk("t2_full_alloc_rdy", 64'(bus.alloc_rdy_o), 64'd0);
    chk("t2_full_occ", 64'(occ), 64'd4);
    tick();
    #2;
    chk("t2_alloc_rdy_next", 64'(bus.alloc_rdy_o), 64'd1);
    exp_q.push_back(mk(10, 1, d_of(10), 0, 1));
    tick();
    drive(0, 0, 0, 1, 0, d_of(10), 1);
    tick();
    drive(0, 0, 0, 0, 0, '0, 1);
    wait_drain("t2_drain");

    // 3: WAW after both allocs clears both; WAW in the younger's alloc cycle clears only the older
    drive(1, 5, 1, 0, 0, '0, 0);
    exp_q.push_back(mk(5, 1, d_of(20), 0, 0));
    tick();
    drive(1, 5, 1, 1, 0, d_of(20), 0);
    exp_q.push_back(mk(5, 1, d_of(21), 0, 0));
    tick();
    drive(0, 0, 0, 1, 0, d_of(21), 0);
    set_waw(1, 5);
    tick();
    drive(1, 5, 1, 0, 0, '0, 0);
    exp_q.push_back(mk(5, 1, d_of(22), 0, 0));
    tick();
    drive(1, 5, 1, 1, 0, d_of(22), 0);
    set_waw(0, 5);
    exp_q.push_back(mk(5, 1, d_of(23), 0, 1));
    tick();
    drive(0, 0, 0, 1, 0, d_of(23), 0);
    tick();
    drive(0, 0, 0, 0, 0, '0, 1);
    wait_drain("t3_drain");

    // 5: store never reports wrsv; a WAW naming x0 touches nothing
    drive(1, 7, 0, 0, 0, '0, 0);
    exp_q.push_back(mk(7, 0, d_of(30), 0, 0));
    tick();
    drive(1, 0, 1, 0, 0, '0, 0);
    set_waw(0, 7);
    exp_q.push_back(mk(0, 1, d_of(31), 0, 1));
    tick();
    drive(1, 3, 1, 0, 0, '0, 0);
    set_waw(0, 0);
    set_waw(1, 0);
    exp_q.push_back(mk(3, 1, d_of(32), 0, 1));
    tick();
    for (int i = 30; i < 33; i++) begin
      drive(0, 0, 0, 1, 0, d_of(i), 0);
      set_waw(0, 0);
      set_waw(1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, '0, 1);
    wait_drain("t5_drain");

    // 4: error response is accepted, then stalls responses until flush
    for (int i = 0; i < 3; i++) begin
      drive(1, 11 + i, 1, 0, 0, '0, 0);
      tick();
    end
    exp_q.push_back(mk(11, 1, d_of(40), 0, 1));
    exp_q.push_back(mk(12, 1, d_of(41), 1, 1));
    drive(0, 0, 0, 1, 0, d_of(40), 0);
    tick();
    drive(0, 0, 0, 1, 1, d_of(41), 0);
    #2;
    chk("t4_err_active_now", 64'(err_act), 64'd1);
    chk("t4_err_resp_accepted", 64'(bus.resp_rdy_o), 64'd1);
    tick();
    drive(0, 0, 0, 1, 0, d_of(42), 0);
    #2;
    chk("t4_resp_rdy_stalled", 64'(bus.resp_rdy_o), 64'd0);
    tick();
    #2;
    chk("t4_resp_rdy_still", 64'(bus.resp_rdy_o), 64'd0);
    drive(0, 0, 0, 0, 0, '0, 1);
    repeat (3) tick();
    #2;
    chk("t4_err_sticky", 64'(err_act), 64'd1);
    chk("t4_occ_before_flush", 64'(occ), 64'd1);
    chk("t4_drained_pair", 64'(exp_q.size()), 64'd0);
    drive(1, 15, 1, 0, 0, '0, 1);
    flush = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0, '0, 1);
    #2;
    chk("t4_flush_occ", 64'(occ), 64'd0);
    chk("t4_flush_err", 64'(err_act), 64'd0);
    chk("t4_flush_resp_rdy", 64'(bus.resp_rdy_o), 64'd1);
    chk("t4_flush_out_valid", 64'(bus.out_valid_o), 64'd0);
    debug = 1'b1;
    drive(1, 14, 1, 0, 0, '0, 0);
    exp_q.push_back(mk(14, 1, d_of(43), 1, 1));
    tick();
    drive(0, 0, 0, 1, 1, d_of(43), 0);
    #2;
    chk("t4_debug_err_active", 64'(err_act), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, '0, 0);
    #2;
    chk("t4_debug_resp_rdy", 64'(bus.resp_rdy_o), 64'd1);
    debug = 1'b0;
    bus.out_rdy_i = 1'b1;
    wait_drain("t4_debug_drain");

    // 6: random commit back-pressure across several pointer wraps
    sent = 0; cyc = 0; base = drained;
    while ((sent < 16 || exp_q.size() != 0) && cyc < 400) begin
      rv = 1'b0; rdat = '0;
      if (pend_q.size() != 0) begin
        rv = 1'b1;
        rdat = pend_q.pop_front();
      end
      av = (sent < 16) && bus.alloc_rdy_o;
      rd = 5'($urandom_range(1, 31));
      we = 1'($urandom);
      adat = {1'($urandom), $urandom, $urandom};
      if (av) begin
        exp_q.push_back(mk(int'(rd), we, adat, 0, we));
        pend_q.push_back(adat);
        sent++;
      end
      drive(av, int'(rd), we, rv, 0, rdat, 1'($urandom));
      tick();
      cyc++;
    end
    drive(0, 0, 0, 0, 0, '0, 1);
    chk("t6_all_committed", 64'(exp_q.size()), 64'd0);
    chk("t6_count", 64'(drained - base), 64'd16);

    // Asynchronous reset in mid-cycle with an entry outstanding
    drive(1, 9, 1, 0, 0, '0, 0);
    tick();
    drive(0, 0, 0, 0, 0, '0, 0);
    #1;
    chk("arst_occ_before", 64'(occ), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_occ", 64'(occ), 64'd0);
    chk("arst_alloc_rdy", 64'(bus.alloc_rdy_o), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
